// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multiport register file.
// Default geometry, zero-register address and flattened-bus slice offsets.
package regfile_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_ADDR  = 0;

  // Low bit of port idx inside a bus built from w-bit fields.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: word mux, zero-register force, optional write bypass
// (REGFILE_WRITE_BYPASS_EN) and optional output register (READ_REG=1).
// Ports: clk/reset, mem (whole array), addr, write bus, rd_data, rd_valid.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int READ_REG = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [2**ADDR_W-1:0][WIDTH-1:0]    mem,
  input  logic [ADDR_W-1:0]                  addr,
  input  logic                               wr_en,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic [WIDTH-1:0]                   wr_data,
  output logic [WIDTH-1:0]                   rd_data,
  output logic                               rd_valid
);

  logic             is_zero;
  logic [WIDTH-1:0] word;

  assign is_zero = (ZERO_REG != 0) &&
                   (addr == ADDR_W'(ZERO_ADDR));

`ifdef REGFILE_WRITE_BYPASS_EN
  // Write-first: the word being written wins over the stored copy.
  always_comb begin
    word = mem[addr];
    if (wr_en && (wr_addr == addr))
      word = wr_data;
    if (is_zero)
      word = '0;
  end
`else
  always_comb begin
    word = mem[addr];
    if (is_zero)
      word = '0;
  end

  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  if (READ_REG != 0) begin : g_reg
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= word;
        valid_q <= 1'b1;
      end
    end

    assign rd_data  = data_q;
    assign rd_valid = valid_q;
  end else begin : g_comb
    logic unused_clk;
    assign unused_clk = clk ^ reset;
    assign rd_data    = word;
    assign rd_valid   = 1'b1;
  end

endmodule

// File: rtl/regfile_multiport.sv
// Register file: 2**ADDR_W words, NUM_RD read ports, one write port.
// Ports: clk, reset (sync, high), wr_en/wr_addr/wr_data, rd_addr,
// rd_data, rd_valid. Optional macro: REGFILE_WRITE_BYPASS_EN.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int READ_REG = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD*WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]         rd_valid
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        wr_ok;

  // Writes to the hardwired zero register are dropped so it stays 0.
  assign wr_ok = wr_en &&
                 !((ZERO_REG != 0) &&
                   (wr_addr == ADDR_W'(ZERO_ADDR)));

  always_ff @(posedge clk) begin
    if (reset)
      mem <= '0;
    else if (wr_ok)
      mem[wr_addr] <= wr_data;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    localparam int ALO = slice_lo(p, ADDR_W);
    localparam int DLO = slice_lo(p, WIDTH);

    regfile_read_port #(
      .WIDTH    (WIDTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .READ_REG (READ_REG)
    ) u_rp (
      .clk      (clk),
      .reset    (reset),
      .mem      (mem),
      .addr     (rd_addr[ALO +: ADDR_W]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data[DLO +: WIDTH]),
      .rd_valid (rd_valid[p])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: a combinational 2-port zero-reg instance
// and a registered 4-port plain instance sharing one write bus.
module tb_regfile_multiport;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data;
  logic [9:0]   rd_addr_a;
  logic [63:0]  rd_data_a;
  logic [1:0]   rd_valid_a;
  logic [19:0]  rd_addr_b;
  logic [127:0] rd_data_b;
  logic [3:0]   rd_valid_b;

  always #5 clk = ~clk;

  regfile_multiport #(
    .WIDTH(32), .ADDR_W(5), .NUM_RD(2),
    .ZERO_REG(1), .READ_REG(0)
  ) dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a)
  );

  regfile_multiport #(
    .WIDTH(32), .ADDR_W(5), .NUM_RD(4),
    .ZERO_REG(0), .READ_REG(1)
  ) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t        tbl[12];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] mb[32];
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic        qv[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // One clock: queue B's expectation, step the model, check B.
  task automatic tick();
    logic [4:0]  ra;
    logic [31:0] e;
    for (int p = 0; p < 4; p++) begin
      ra = rd_addr_b[p*5 +: 5];
      if (reset)
        e = 32'h0;
      else if (BYP && wr_en && wr_addr == ra)
        e = wr_data;
      else
        e = mb[ra];
      qb.push_back(e);
      qv.push_back(!reset);
    end
    @(posedge clk);
    if (reset)
      for (int i = 0; i < 32; i++) mb[i] = 32'h0;
    else if (wr_en)
      mb[wr_addr] = wr_data;
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("b_data%0d", p),
          rd_data_b[p*32 +: 32], qb.pop_front());
      chk($sformatf("b_valid%0d", p),
          {31'h0, rd_valid_b[p]}, {31'h0, qv.pop_front()});
    end
  endtask

  task automatic check_a(input string nm);
    #1;
    chk({nm, "_p0"}, rd_data_a[31:0], qa.pop_front());
    chk({nm, "_p1"}, rd_data_a[63:32], qa.pop_front());
    chk({nm, "_vld"}, {30'h0, rd_valid_a}, 32'h3);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mb[i] = 32'hx;

    tbl[0]  = '{1'b1, 1'b1, 5'd3, 32'hAAAA5555, 5'd4, 5'd0,
                32'h0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd3, 5'd5,
                32'h0, BYP ? 32'hDEADBEEF : 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5,
                32'hDEADBEEF, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0,
                32'h0, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5,
                32'h0, 32'hDEADBEEF};
    tbl[5]  = '{1'b0, 1'b1, 5'd7, 32'h1, 5'd7, 5'd1,
                BYP ? 32'h1 : 32'h0, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7,
                BYP ? 32'h12345678 : 32'h1,
                BYP ? 32'h12345678 : 32'h1};
    tbl[7]  = '{1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0,
                32'h12345678, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd30,
                BYP ? 32'hA5A5A5A5 : 32'h0, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd7,
                32'hA5A5A5A5, 32'h12345678};
    tbl[10] = '{1'b1, 1'b0, 5'd0, 32'h0, 5'd31, 5'd5,
                32'hA5A5A5A5, 32'hDEADBEEF};
    tbl[11] = '{1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd5,
                32'h0, 32'h0};

    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = 5'd0;
    wr_data   = 32'h0;
    rd_addr_a = 10'h0;
    rd_addr_b = 20'h0;
    tick();
    tick();

    reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd_addr_a = {5'(31 - a), 5'(a)};
      rd_addr_b = {4{5'(a)}};
      qa.push_back(32'h0);
      qa.push_back(32'h0);
      check_a("a_reset_rd");
      tick();
    end

    for (int i = 0; i < 12; i++) begin
      reset     = tbl[i].rst;
      wr_en     = tbl[i].we;
      wr_addr   = tbl[i].wa;
      wr_data   = tbl[i].wd;
      rd_addr_a = {tbl[i].ra1, tbl[i].ra0};
      rd_addr_b = {5'd7, 5'd0, tbl[i].ra1, tbl[i].ra0};
      qa.push_back(tbl[i].e0);
      qa.push_back(tbl[i].e1);
      check_a($sformatf("a_vec%0d", i));
      tick();
    end

    // Preload 1..4 into 10..13, then read them back on four ports.
    for (int i = 0; i < 4; i++) begin
      wr_en     = 1'b1;
      wr_addr   = 5'(10 + i);
      wr_data   = 32'(i + 1);
      rd_addr_b = 20'h0;
      tick();
    end
    wr_en     = 1'b0;
    rd_addr_b = {5'd13, 5'd12, 5'd11, 5'd10};
    rd_addr_a = {5'd13, 5'd10};
    qa.push_back(32'h1);
    qa.push_back(32'h4);
    check_a("a_preload");
    tick();
    chk("b_slice0", rd_data_b[31:0], 32'h1);
    chk("b_slice1", rd_data_b[63:32], 32'h2);
    chk("b_slice2", rd_data_b[95:64], 32'h3);
    chk("b_slice3", rd_data_b[127:96], 32'h4);
    chk("b_valid_all", {28'h0, rd_valid_b}, 32'hF);

    // Mid-stream reset drops valid and clears the registered data.
    reset = 1'b1;
    tick();
    chk("b_rst_valid", {28'h0, rd_valid_b}, 32'h0);
    reset = 1'b0;
    tick();
    chk("b_post_rst", rd_data_b[31:0], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
Parametrised register file, the successor to the flat 32-way word mux. Holds DEPTH words of WIDTH bits, with NUM_RD independent read ports and one synchronous write port. Optionally hardwires register 0 to zero and optionally registers read data (1-cycle latency). Sits in the CPU decode stage, feeding ALU operands; also used as a generic small scratch store.

Parameters:
WIDTH, 32, data word width in bits (>=1)
ADDR_W, 5, address width; DEPTH = 2**ADDR_W words
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes; 0 = ordinary storage
READ_REG, 0, 0 = combinational read; 1 = read data registered, latency 1 cycle

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clk
wr_en  input  1  write enable
wr_addr  input  ADDR_W  write address
wr_data  input  WIDTH  write data
rd_addr  input  NUM_RD*ADDR_W  read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*WIDTH  read data; port p on bits [p*WIDTH +: WIDTH]
rd_valid  output  NUM_RD  per-port data-valid flag (meaningful when READ_REG=1; tied all-ones when READ_REG=0)

Behaviour:
- Reset (reset=1 at clk edge): every storage word := 0. When READ_REG=1, rd_data := 0 and rd_valid := 0. reset has priority over wr_en in the same cycle; no write occurs.
- Write: on clk edge with reset=0 and wr_en=1, mem[wr_addr] := wr_data. Visible to reads from the next cycle (without the bypass feature).
- ZERO_REG=1: writes to address 0 are discarded; any read of address 0 returns 0 regardless of history.
- READ_REG=0: rd_data[p] = mem[rd_addr[p]], purely combinational; rd_valid = all ones.
- READ_REG=1: at each clk edge with reset=0, rd_data[p] := mem[rd_addr[p]] using the pre-write contents, and rd_valid[p] := 1. The first edge after reset deasserts produces valid data one cycle later.
- Multiple ports may read the same address in the same cycle; each returns the identical word.
- Out-of-range addresses cannot occur, since DEPTH = 2**ADDR_W.
- Reset asserted mid-stream in READ_REG=1 mode drops rd_valid to 0 in the same edge; data in flight is discarded.
- No X propagation: all storage is reset, so every read after reset is defined.

Optional Feature:
Macro REGFILE_WRITE_BYPASS_EN.
- Defined: a read whose address equals wr_addr while wr_en=1 (and the address is not the zero register when ZERO_REG=1) returns wr_data in the same cycle (READ_REG=0), or captures wr_data at the edge (READ_REG=1). This is write-first semantics.
- Undefined: read-before-write. Same-cycle reads return the old contents.

Decomposition:
- Package regfile_pkg: default WIDTH/ADDR_W constants, ZERO_ADDR constant, and a function to slice a flattened port index.
- Sub-module regfile_read_port: one read mux plus bypass compare plus optional output register.
- Top-level: storage array and write logic; instantiates NUM_RD copies of regfile_read_port via generate.

Test Plan:
- Reset then read all 32 addresses on both ports -> every rd_data = 0x00000000; with READ_REG=1, rd_valid = 0 until the first post-reset edge.
- Write 0xDEADBEEF to addr 5, then read port0=5, port1=5 next cycle -> both ports return 0xDEADBEEF.
- ZERO_REG=1: write 0xFFFFFFFF to addr 0, then read addr 0 -> 0x00000000. With ZERO_REG=0 the same sequence reads back 0xFFFFFFFF.
- Same-cycle write of 0x12345678 to addr 7 while port0 reads 7 (mem[7] previously 0x1) -> 0x00000001 without REGFILE_WRITE_BYPASS_EN; 0x12345678 with it.
- Assert reset and wr_en together with addr 3 / data 0xAAAA5555 -> mem[3] stays 0 on the next read.
- READ_REG=1, NUM_RD=4: drive four distinct addresses with preloaded values 1,2,3,4 -> values appear one cycle later on the correct slices, and rd_valid = 4'b1111.
